// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memop encoding, FSM states and
// the load-result extension helper.
package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LBEAT,
    LCAPT,
    SBEAT,
    RESP
  } state_t;

  // Final extension of a byte-merged misaligned load.
  function automatic logic [31:0] extend_load(input logic [2:0] memop, input logic [31:0] raw);
    case (memop)
      MEMOP_H:  extend_load = {{16{raw[15]}}, raw[15:0]};
      MEMOP_HU: extend_load = {16'h0000, raw[15:0]};
      default:  extend_load = raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_req_decode.sv
// Request classification: legality of the memop for the access direction,
// misalignment against the address low bits, and access size in bytes.
module lsu_req_decode
  import lsu_pkg::*;
(
  input  logic [2:0] memop,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic       legal,
  output logic       misaligned,
  output logic [2:0] nbytes
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    nbytes     = 3'd1;
    case (memop)
      MEMOP_B, MEMOP_BU: begin
        legal  = !we || (memop == MEMOP_B);
        nbytes = 3'd1;
      end
      MEMOP_H, MEMOP_HU: begin
        legal      = !we || (memop == MEMOP_H);
        misaligned = addr_lo[0];
        nbytes     = 3'd2;
      end
      MEMOP_W: begin
        legal      = 1'b1;
        misaligned = |addr_lo;
        nbytes     = 3'd4;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: issues one core request at a time to the data memory,
// splitting misaligned accesses into sequential byte beats.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_memop,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic [2:0]  op_memop;
  logic [31:0] op_wdata;
  logic        op_mis;
  logic [1:0]  op_last;
  logic [1:0]  cnt;
  logic [31:0] rbuf;

  logic        legal;
  logic        misaligned;
  logic [2:0]  nbytes;
  logic [1:0]  cnt_nx;
  logic [31:0] merged;
  logic [31:0] load_result;

  lsu_req_decode u_dec (
    .memop      (req_memop),
    .addr_lo    (req_addr[1:0]),
    .we         (req_we),
    .legal      (legal),
    .misaligned (misaligned),
    .nbytes     (nbytes)
  );

  assign req_ready = (state == IDLE);
  assign cnt_nx    = cnt + 2'd1;

  // The memory returns each byte beat zero-extended in the low lane.
  always_comb begin
    merged = rbuf;
    merged[{cnt, 3'b000} +: 8] = mem_rdata[7:0];
  end

  assign load_result = op_mis ? extend_load(op_memop, merged) : mem_rdata;

  // NOTE: all state, including the merge buffer, is cleared by reset so an
  // interrupted access leaves nothing behind; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_memop  <= MEMOP_B;
      op_wdata  <= '0;
      op_mis    <= 1'b0;
      op_last   <= 2'd0;
      cnt       <= 2'd0;
      rbuf      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_memop <= MEMOP_B;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: if (req_valid) begin
          op_memop <= req_memop;
          op_wdata <= req_wdata;
          op_mis   <= misaligned;
          op_last  <= !misaligned ? 2'd0 : (nbytes == 3'd4) ? 2'd3 : 2'd1;
          cnt      <= 2'd0;
          rbuf     <= '0;
          if (!legal) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            mem_addr  <= req_addr;
            mem_memop <= !misaligned ? req_memop : (req_we ? MEMOP_B : MEMOP_BU);
            mem_we    <= req_we;
            mem_wdata <= !req_we ? 32'h0 : misaligned ? {24'h0, req_wdata[7:0]} : req_wdata;
            state     <= req_we ? SBEAT : LBEAT;
          end
        end
        SBEAT: begin
          if (cnt == op_last) begin
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt       <= cnt_nx;
            mem_addr  <= mem_addr + 32'd1;
            mem_wdata <= {24'h0, op_wdata[{cnt_nx, 3'b000} +: 8]};
          end
        end
        LBEAT: state <= LCAPT;
        LCAPT: begin
          if (cnt == op_last) begin
            rsp_rdata <= load_result;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            rbuf     <= merged;
            cnt      <= cnt_nx;
            mem_addr <= mem_addr + 32'd1;
            state    <= LBEAT;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-array data memory model that answers
// one cycle after the address, lane-extracted per memop.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [2:0]  mem_memop;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:255];
  logic       pk_en = 1'b0;
  logic [7:0] pk_idx = 8'h00;
  logic [7:0] pk_dat = 8'h00;

  lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_memop (req_memop),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_memop (mem_memop),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] op);
    logic [7:0] i0, i1, i2, i3;
    i0 = a[7:0];
    i1 = i0 + 8'd1;
    i2 = i0 + 8'd2;
    i3 = i0 + 8'd3;
    case (op)
      3'b000:  rd = {{24{mem[i0][7]}}, mem[i0]};
      3'b100:  rd = {24'h0, mem[i0]};
      3'b001:  rd = {{16{mem[i1][7]}}, mem[i1], mem[i0]};
      3'b101:  rd = {16'h0, mem[i1], mem[i0]};
      default: rd = {mem[i3], mem[i2], mem[i1], mem[i0]};
    endcase
  endfunction

  // Memory model: 256 bytes indexed by addr[7:0]; writes and read sampling on the edge.
  always @(posedge clk) begin
    if (pk_en) mem[pk_idx] <= pk_dat;
    if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_memop != 3'b000) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_memop == 3'b010) begin
        mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
    mem_rdata <= rd(mem_addr, mem_memop);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [7:0] dat);
    @(negedge clk);
    pk_en  = 1'b1;
    pk_idx = idx;
    pk_dat = dat;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  // Presents a request in cycle 0, accepted at edge 0; returns sampling in cycle 1.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_memop = op;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_memop = 3'b111;
    req_addr  = 32'h5A5A_5A5A;
    req_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_memop = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
    #12;
    check("rst req_ready", {31'b0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_memop", {29'b0, mem_memop}, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned SW 0x100
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    check("sw c1 mem_we", {31'b0, mem_we}, 32'd1);
    check("sw c1 mem_memop", {29'b0, mem_memop}, 32'h2);
    check("sw c1 mem_addr", mem_addr, 32'h0000_0100);
    check("sw c1 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw c1 req_ready", {31'b0, req_ready}, 32'd0);
    check("sw c1 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("sw c2 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("sw c2 rsp_err", {31'b0, rsp_err}, 32'd0);
    check("sw c2 rsp_rdata", rsp_rdata, 32'h0);
    check("sw c2 mem_we", {31'b0, mem_we}, 32'd0);
    check("sw c2 mem_wdata", mem_wdata, 32'h0);
    check("sw c2 mem_addr held", mem_addr, 32'h0000_0100);
    step();
    check("sw c3 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("sw c3 req_ready", {31'b0, req_ready}, 32'd1);
    check("sw mem bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'hDEAD_BEEF);

    // Aligned LB 0x103, byte 0x80
    poke(8'h03, 8'h80);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check("lb c1 mem_addr", mem_addr, 32'h0000_0103);
    check("lb c1 mem_memop", {29'b0, mem_memop}, 32'h0);
    check("lb c1 mem_we", {31'b0, mem_we}, 32'd0);
    step();
    check("lb c2 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("lb c3 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lb c3 rsp_rdata", rsp_rdata, 32'hFFFF_FF80);

    // Misaligned LW 0x101, bytes 11 22 33 44
    poke(8'h01, 8'h11);
    poke(8'h02, 8'h22);
    poke(8'h03, 8'h33);
    poke(8'h04, 8'h44);
    issue(1'b0, 3'b010, 32'h0000_0101, 32'h0);
    check("lw b0 addr", mem_addr, 32'h0000_0101);
    check("lw b0 memop", {29'b0, mem_memop}, 32'h4);
    step();
    check("lw c2 addr held", mem_addr, 32'h0000_0101);
    step();
    check("lw b1 addr", mem_addr, 32'h0000_0102);
    step();
    step();
    check("lw b2 addr", mem_addr, 32'h0000_0103);
    step();
    step();
    check("lw b3 addr", mem_addr, 32'h0000_0104);
    check("lw b3 memop", {29'b0, mem_memop}, 32'h4);
    step();
    check("lw c8 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("lw c9 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lw c9 rsp_rdata", rsp_rdata, 32'h4433_2211);

    // Misaligned LH / LHU 0x105, bytes F0 80
    poke(8'h05, 8'hF0);
    poke(8'h06, 8'h80);
    issue(1'b0, 3'b001, 32'h0000_0105, 32'h0);
    repeat (3) step();
    check("lh c4 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    check("lh c5 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lh c5 rsp_rdata", rsp_rdata, 32'hFFFF_80F0);
    step();
    issue(1'b0, 3'b101, 32'h0000_0105, 32'h0);
    repeat (4) step();
    check("lhu c5 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("lhu c5 rsp_rdata", rsp_rdata, 32'h0000_80F0);
    step();

    // Misaligned SH 0xFFFFFFFF wrapping to 0
    issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h1234_ABCD);
    check("sh b0 addr", mem_addr, 32'hFFFF_FFFF);
    check("sh b0 memop", {29'b0, mem_memop}, 32'h0);
    check("sh b0 wdata", mem_wdata, 32'h0000_00CD);
    check("sh b0 we", {31'b0, mem_we}, 32'd1);
    step();
    check("sh b1 addr", mem_addr, 32'h0000_0000);
    check("sh b1 wdata", mem_wdata, 32'h0000_00AB);
    check("sh b1 we", {31'b0, mem_we}, 32'd1);
    step();
    check("sh c3 rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("sh c3 mem_we", {31'b0, mem_we}, 32'd0);
    check("sh mem bytes", {16'h0, mem[8'h00], mem[8'hFF]}, 32'h0000_ABCD);
    step();

    // Illegal store memop 100, illegal load memop 011
    issue(1'b1, 3'b100, 32'h0000_0040, 32'hFFFF_FFFF);
    check("ill st rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("ill st rsp_err", {31'b0, rsp_err}, 32'd1);
    check("ill st rsp_rdata", rsp_rdata, 32'h0);
    check("ill st mem_we", {31'b0, mem_we}, 32'd0);
    check("ill st mem_addr held", mem_addr, 32'h0000_0000);
    step();
    check("ill st c2 rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("ill st c2 rsp_err", {31'b0, rsp_err}, 32'd0);
    check("ill st c2 mem_we", {31'b0, mem_we}, 32'd0);
    check("ill st c2 req_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 3'b011, 32'h0000_0040, 32'h0);
    check("ill ld rsp_err", {31'b0, rsp_err}, 32'd1);
    check("ill ld rsp_valid", {31'b0, rsp_valid}, 32'd1);
    step();

    // Reset during the second beat of a misaligned SW at 0x201
    issue(1'b1, 3'b010, 32'h0000_0201, 32'h5566_7788);
    check("rsw b0 wdata", mem_wdata, 32'h0000_0088);
    step();
    check("rsw b1 addr", mem_addr, 32'h0000_0202);
    check("rsw b1 we", {31'b0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rsw mem_we async", {31'b0, mem_we}, 32'd0);
    check("rsw mem_addr cleared", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | rsp_valid | mem_we;
    end
    check("rsw no rsp/we after reset", {31'b0, seen}, 32'd0);
    check("rsw req_ready", {31'b0, req_ready}, 32'd1);
    check("rsw partial byte0", {24'h0, mem[8'h01]}, 32'h0000_0088);
    check("rsw byte1 untouched", {24'h0, mem[8'h02]}, 32'h0000_0022);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
